// File: rtl/fp_align_accum.sv
// fp_align_accum: aligns narrow signed fixed-point samples to a wide format and emits saturated block sums.
module fp_align_accum #(
  parameter int NB_XI  = 8,
  parameter int NBF_XI = 6,
  parameter int NB_XO  = 12,
  parameter int NBF_XO = 8,
  parameter int LOG2_N = 2
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_valid,
  output logic              o_ready,
  input  logic [NB_XI-1:0]  i_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [NB_XO-1:0]  o_data,
  output logic              o_ovf
);
  localparam int NA = NB_XO + LOG2_N;
  localparam int CW = LOG2_N > 0 ? LOG2_N : 1;
  localparam int SH = NBF_XO - NBF_XI;
  localparam logic [CW-1:0] LAST = CW'((1 << LOG2_N) - 1);
  if (NBF_XO < NBF_XI || (NB_XO - NBF_XO) < (NB_XI - NBF_XI)) begin : g_bad_format
    $error("fp_align_accum: output format narrower than input format");
  end
  logic signed [NB_XO-1:0] aligned;
  logic signed [NA-1:0]    acc, acc_next;
  logic [CW-1:0]           cnt;
  logic [LOG2_N:0]         top;
  logic                    last, accept, ovf;
  logic [NB_XO-1:0]        sum;
  assign aligned  = NB_XO'($signed(i_data)) <<< SH;
  assign last     = cnt == LAST;
  assign o_ready  = ~(last & o_valid & ~i_ready);
  assign accept   = i_valid & o_ready;
  assign acc_next = (cnt == '0 ? '0 : acc) + NA'(aligned);
  // guard bits plus the output MSB must all match the sign for the sum to fit
  assign top      = acc_next[NA-1:NB_XO-1];
  assign ovf      = ~(&top) & (|top);
  assign sum      = ovf ? {acc_next[NA-1], {(NB_XO-1){~acc_next[NA-1]}}} : acc_next[NB_XO-1:0];
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      acc     <= '0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_ovf   <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_next;
        cnt <= last ? '0 : cnt + 1'b1;
      end
      if (accept & last) begin
        o_valid <= 1'b1;
        o_data  <= sum;
        o_ovf   <= ovf;
      end else if (i_ready) begin
        o_valid <= 1'b0;
      end
    end
  end
endmodule

// File: doc/fp_align_accum.md
Name: fp_align_accum

Overview:
- Widening counterpart of the team's saturate/round quantizer: takes narrow signed fixed-point samples S(NB_XI,NBF_XI) and aligns each one to the wide full-precision format S(NB_XO,NBF_XO).
- Accumulates blocks of N = 2**LOG2_N aligned samples and emits one full-precision sum per block, with saturation and an overflow flag.
- Sits between the narrow datapath (FIR taps / quantized samples) and wide accumulation logic that later feeds the quantizer.

Parameters:
- NB_XI, 8, total bits of input sample (signed).
- NBF_XI, 6, fractional bits of input sample.
- NB_XO, 12, total bits of output sum (signed).
- NBF_XO, 8, fractional bits of output sum.
- LOG2_N, 2, log2 of samples per block; 0 gives N=1 (pass-through with register).
- Legal only if NBF_XO >= NBF_XI and (NB_XO-NBF_XO) >= (NB_XI-NBF_XI). Any other setting is an elaboration error.

Ports:
- i_clock, in, 1, single clock, rising edge.
- i_reset, in, 1, asynchronous active-low reset.
- i_valid, in, 1, input sample valid.
- o_ready, out, 1, block accepts input this cycle.
- i_data, in, NB_XI, input sample S(NB_XI,NBF_XI).
- o_valid, out, 1, output sum valid.
- i_ready, in, 1, downstream accepts output.
- o_data, out, NB_XO, block sum S(NB_XO,NBF_XO), saturated.
- o_ovf, out, 1, sum saturated; qualified by o_valid.

Behaviour:
- Reset (i_reset=0, async assert, sync release): accumulator=0, counter=0, o_valid=0, o_data=0, o_ovf=0. o_ready=1 once reset is released. A partial block in flight is discarded.
- Alignment (combinational):
  - sign-extend the integer part by (NBI_XO-NBI_XI) copies of i_data MSB;
  - append (NBF_XO-NBF_XI) zero LSBs;
  - the result is exact, with no rounding.
- Accumulator: NB_XO+LOG2_N bits signed (guard bits). An accept is i_valid & o_ready.
  - On accept with counter==0: acc <= aligned.
  - Otherwise: acc <= acc + aligned.
  - The counter increments modulo N on every accept.
- Block close: on accept with counter==N-1, the final sum acc_next = (counter==0 ? aligned : acc+aligned) is saturated to NB_XO bits:
  - if the guard bits plus the MSB of the NB_XO field are not all equal to the sign, o_data = {sign, (NB_XO-1){~sign}} and o_ovf=1;
  - else o_data = low NB_XO bits and o_ovf=0.
  - o_data/o_ovf are loaded into the output register and o_valid=1 on the next edge. Latency is 1 cycle from the last accept.
  - The counter returns to 0, and the next block starts on the following accept with no bubble.
- Output handshake:
  - o_valid stays 1 and o_data/o_ovf stay stable until i_valid... is irrelevant here: they hold until i_ready=1.
  - o_valid is cleared on an edge with o_valid & i_ready, unless a new block closes on that same edge, in which case the new sum is loaded and o_valid remains 1.
- Backpressure: o_ready = ~(counter==N-1 & o_valid & ~i_ready).
  - Samples 0..N-2 of the next block are always accepted while output is pending.
  - Only the closing sample stalls.
  - Simultaneous close and output consume is allowed and gives full throughput of 1 sample/cycle.
- No internal arithmetic wrap is possible: N aligned samples always fit in NB_XO+LOG2_N bits.
- i_data is ignored when i_valid=0. o_ovf is don't-care while o_valid=0 but holds its last value.

Test Plan:
- Defaults, i_ready=1, 4 accepts of 0x40 (1.0) -> one cycle after the 4th accept: o_valid=1, o_data=0x400 (4.0), o_ovf=0.
- Defaults, samples 0x40,0xC0,0x20,0x01 (1,-1,0.5,1/64) -> o_data=0x084 (0.515625), o_ovf=0. Four samples of 0x80 (-2.0) -> o_data=0x800 (-8.0), o_ovf=0 (exact minimum, no saturation).
- NB_XO=10, NBF_XO=8: 4×0x7F -> o_data=0x1FF, o_ovf=1. Then 4×0x80 -> o_data=0x200, o_ovf=1. Then 4×0x10 (0.25) -> o_data=0x100, o_ovf=0.
- Backpressure, defaults: i_ready=0 after the first block, 8 consecutive valid samples of 0x40:
  - samples 5-7 are accepted;
  - sample 8 sees o_ready=0 while the first sum is held;
  - raising i_ready for one cycle consumes 0x400, and the 8th sample is accepted on the same edge;
  - o_valid stays 1 with the second 0x400.
- Reset mid-block: accept 2×0x7F, assert i_reset=0 asynchronously between edges -> o_valid, o_data, o_ovf drop to 0 immediately. After release, 4×0x40 -> o_data=0x400, with no residue from before reset.
- LOG2_N=0, defaults: a stream of 0x20, 0xE0 on consecutive cycles with i_ready=1 -> o_data=0x080 then 0xF80 one cycle after each accept, o_valid continuously 1.
